// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: 2^INDEX_BITS lines of 16 B between CPU fetch and block memory.
// Latency: hits are combinational; a miss stalls for (memory busy cycles + 2) cycles, then completes as a hit.
// Backpressure: busywait stalls the CPU during a miss; the block fetch waits on mem_busywait.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   read, address         CPU fetch request and 10-bit byte PC
//   instruction, busywait fetched word, CPU stall
//   mem_read, mem_address block read request and 6-bit block address {tag,index}
//   mem_readdata          128-bit block returned by memory
//   mem_busywait          memory busy while a block read is in flight
//   hit_count, miss_count saturating fetch statistics (only with ICACHE_STATS_EN)
//
// Optional feature macro: ICACHE_STATS_EN
module instruction_cache #(
  parameter int INDEX_BITS = 3
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         read,
  input  logic [9:0]   address,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readdata,
`ifdef ICACHE_STATS_EN
  input  logic         mem_busywait,
  output logic [15:0]  hit_count,
  output logic [15:0]  miss_count
`else
  input  logic         mem_busywait
`endif
);

  localparam int LINES    = 1 << INDEX_BITS;
  localparam int TAG_BITS = 6 - INDEX_BITS;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  state_t state, next_state;

  logic [127:0]          data_array [LINES];
  logic [TAG_BITS-1:0]   tag_array  [LINES];
  logic [LINES-1:0]      valid;

  // Block address of the outstanding miss; the fill always targets this,
  // whatever the CPU does with address meanwhile.
  logic [5:0]            miss_addr;

  logic [TAG_BITS-1:0]   addr_tag;
  logic [INDEX_BITS-1:0] addr_index;
  logic [1:0]            addr_offset;
  logic [TAG_BITS-1:0]   miss_tag;
  logic [INDEX_BITS-1:0] miss_index;
  logic                  hit;
  logic                  unused_byte_bits;

  assign addr_tag         = address[9:4+INDEX_BITS];
  assign addr_index       = address[3+INDEX_BITS:4];
  assign addr_offset      = address[3:2];
  assign unused_byte_bits = ^address[1:0];

  assign miss_tag   = miss_addr[5:INDEX_BITS];
  assign miss_index = miss_addr[INDEX_BITS-1:0];

  assign hit = valid[addr_index] && (tag_array[addr_index] == addr_tag);

  always_comb begin
    case (addr_offset)
      2'd0:    instruction = data_array[addr_index][31:0];
      2'd1:    instruction = data_array[addr_index][63:32];
      2'd2:    instruction = data_array[addr_index][95:64];
      default: instruction = data_array[addr_index][127:96];
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state  = state;
    busywait    = 1'b0;
    mem_read    = 1'b0;
    mem_address = 6'd0;
    case (state)
      IDLE: begin
        busywait = read && !hit;
        if (read && !hit) begin
          next_state = MEM_READ;
        end
      end
      MEM_READ: begin
        mem_read    = 1'b1;
        mem_address = miss_addr;
        busywait    = 1'b1;
        // Memory raises mem_busywait together with mem_read, so the first
        // cycle here never exits early.
        if (!mem_busywait) begin
          next_state = UPDATE;
        end
      end
      UPDATE: begin
        busywait   = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      miss_addr <= 6'd0;
    end else if (state == IDLE && read && !hit) begin
      miss_addr <= address[9:4];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else if (state == UPDATE) begin
      valid[miss_index] <= 1'b1;
    end
  end

  // Data and tag arrays carry no reset; the valid bits gate their use.
  always_ff @(posedge clock) begin
    if (state == UPDATE) begin
      data_array[miss_index] <= mem_readdata;
      tag_array[miss_index]  <= miss_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hit_count  <= 16'd0;
      miss_count <= 16'd0;
    end else if (state == IDLE && read) begin
      if (hit) begin
        if (hit_count != 16'hFFFF) begin
          hit_count <= hit_count + 16'd1;
        end
      end else if (miss_count != 16'hFFFF) begin
        miss_count <= miss_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instruction_cache.sv
module tb_instruction_cache;

  logic         clock;
  logic         reset;
  logic         read;
  logic [9:0]   address;
  logic [31:0]  instruction;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef ICACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  int tests = 0;
  int fails = 0;

  instruction_cache #(.INDEX_BITS(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .address      (address),
    .instruction  (instruction),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
`ifdef ICACHE_STATS_EN
    .mem_busywait (mem_busywait),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`else
    .mem_busywait (mem_busywait)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Instruction memory model: busy for MEM_LAT cycles after mem_read rises,
  // holds the block for the address last requested.
  localparam int MEM_LAT = 3;
  int       mem_cnt = 0;
  logic [5:0] mem_addr_q = 6'd0;

  always @(posedge clock) begin
    if (mem_read) begin
      mem_cnt    <= mem_cnt + 1;
      mem_addr_q <= mem_address;
    end else begin
      mem_cnt    <= 0;
    end
  end

  function automatic logic [127:0] block_of(input logic [5:0] a);
    case (a)
      6'd0:    block_of = {32'h03010103, 32'h0A0B0C0D, 32'h0002000C, 32'h0001000F};
      6'd4:    block_of = {32'h44444443, 32'h44444442, 32'h44444441, 32'h0F060022};
      6'd8:    block_of = {32'h88888883, 32'h88888882, 32'h88888881, 32'hDEADBEEF};
      default: block_of = {4{26'h0, a}};
    endcase
  endfunction

  assign mem_busywait = mem_read && (mem_cnt < MEM_LAT);
  assign mem_readdata = block_of(mem_addr_q);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Issue a fetch expected to miss; checks the memory request and waits
  // (bounded) for the stall to clear.
  task automatic fetch_miss(input string tag, input logic [9:0] a, input logic [5:0] blk);
    read    = 1'b1;
    address = a;
    #1;
    check({tag, "_stall"}, {31'd0, busywait}, 32'd1);
    tick();
    check({tag, "_mem_read"}, {31'd0, mem_read}, 32'd1);
    check({tag, "_mem_addr"}, {26'd0, mem_address}, {26'd0, blk});
    for (int i = 0; i < 20 && busywait; i++) tick();
    check({tag, "_fill_done"}, {31'd0, busywait}, 32'd0);
  endtask

  task automatic fetch_hit(input string tag, input logic [9:0] a, input logic [31:0] exp);
    read    = 1'b1;
    address = a;
    #1;
    check({tag, "_busy"}, {31'd0, busywait}, 32'd0);
    check({tag, "_instr"}, instruction, exp);
    check({tag, "_mem_read"}, {31'd0, mem_read}, 32'd0);
    tick();
  endtask

  initial begin
    reset   = 1'b1;
    read    = 1'b0;
    address = 10'd0;
    #12;
    check("rst_busywait", {31'd0, busywait}, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_addr", {26'd0, mem_address}, 32'd0);
`ifdef ICACHE_STATS_EN
    check("rst_hits", {16'd0, hit_count}, 32'd0);
    check("rst_misses", {16'd0, miss_count}, 32'd0);
`endif
    reset = 1'b0;
    tick();

    // Cold miss with exact cycle timing: 3 busy cycles + 2.
    read    = 1'b1;
    address = 10'd0;
    #1;
    check("cold_stall", {31'd0, busywait}, 32'd1);
    check("cold_idle_no_req", {31'd0, mem_read}, 32'd0);
    tick();
    check("cold_mem_read", {31'd0, mem_read}, 32'd1);
    check("cold_mem_addr", {26'd0, mem_address}, 32'd0);
    tick(); tick(); tick();
    check("cold_still_reading", {31'd0, mem_read}, 32'd1);
    tick();
    check("cold_update_no_req", {31'd0, mem_read}, 32'd0);
    check("cold_update_stall", {31'd0, busywait}, 32'd1);
    tick();
    check("cold_done", {31'd0, busywait}, 32'd0);
    check("cold_instr", instruction, 32'h0001000F);
    read = 1'b0;
    tick();

    // Same-block hits.
    fetch_hit("hit4", 10'd4, 32'h0002000C);
    fetch_hit("hit12", 10'd12, 32'h03010103);
    fetch_hit("hit8", 10'd8, 32'h0A0B0C0D);

    // Second line (index 4); line 0 unaffected.
    fetch_miss("line4", 10'd64, 6'd4);
    check("line4_instr", instruction, 32'h0F060022);
    fetch_hit("hit0_after_line4", 10'd0, 32'h0001000F);

    // Conflict on index 0; address moves to a resident line mid-miss, the
    // fill still targets the latched block.
    read    = 1'b1;
    address = 10'd128;
    tick();
    check("conf_mem_addr", {26'd0, mem_address}, 32'd8);
    address = 10'd64;
    for (int i = 0; i < 20 && busywait; i++) tick();
    check("conf_fill_done", {31'd0, busywait}, 32'd0);
    check("conf_new_addr_instr", instruction, 32'h0F060022);
    fetch_hit("hit128", 10'd128, 32'hDEADBEEF);

    // Evicted block 0 refetched; read drops mid-miss, fill still completes.
    read    = 1'b1;
    address = 10'd0;
    #1;
    check("evict_stall", {31'd0, busywait}, 32'd1);
    tick();
    check("evict_mem_addr", {26'd0, mem_address}, 32'd0);
    check("evict_mem_read", {31'd0, mem_read}, 32'd1);
    read = 1'b0;
    #1;
    check("drop_still_busy", {31'd0, busywait}, 32'd1);
    for (int i = 0; i < 20 && (mem_read || busywait); i++) tick();
    tick();
    check("drop_idle_busy", {31'd0, busywait}, 32'd0);
    fetch_hit("refilled0", 10'd0, 32'h0001000F);

    // Asynchronous reset in the middle of a block read.
    read    = 1'b1;
    address = 10'd128;
    tick();
    check("arst_pre_mem_read", {31'd0, mem_read}, 32'd1);
    read = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("arst_mem_read", {31'd0, mem_read}, 32'd0);
    check("arst_busywait", {31'd0, busywait}, 32'd0);
    check("arst_mem_addr", {26'd0, mem_address}, 32'd0);
    reset = 1'b0;
    tick();
    tick();
    fetch_miss("post_rst", 10'd0, 6'd0);
    check("post_rst_instr", instruction, 32'h0001000F);
    read = 1'b0;
    tick();

`ifdef ICACHE_STATS_EN
    // Fetch sequence 0,4,8,64,0 from a cold cache: the fill-completing
    // cycles drop read before the next edge, so only true hits count.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    tick();
    fetch_miss("st0", 10'd0, 6'd0);
    read = 1'b0;
    tick();
    fetch_hit("st4", 10'd4, 32'h0002000C);
    fetch_hit("st8", 10'd8, 32'h0A0B0C0D);
    fetch_miss("st64", 10'd64, 6'd4);
    read = 1'b0;
    tick();
    fetch_hit("st0b", 10'd0, 32'h0001000F);
    read = 1'b0;
    tick();
    check("stats_misses", {16'd0, miss_count}, 32'd2);
    check("stats_hits", {16'd0, hit_count}, 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_cache.md
Name: instruction_cache

Overview:
- Direct-mapped instruction cache between the CPU fetch stage (PC) and the 16-byte-block instruction memory.
- Returns a 32-bit instruction for a 10-bit byte PC.
- On a miss, stalls the CPU via busywait and fetches the 128-bit block over the memory's read/busywait handshake.
- Fills the line, then serves the fetch as a hit.

Parameters:
- INDEX_BITS, 3, set-index width: 2^INDEX_BITS lines of 16 B. Tag width = 6 - INDEX_BITS; block address is fixed at 6 bits.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high; clears valid bits and the FSM.
- read  in  1  CPU fetch request.
- address  in  10  CPU byte PC. [9:4+INDEX_BITS] tag, [3+INDEX_BITS:4] index, [3:2] word offset, [1:0] ignored.
- instruction  out  32  selected word of the indexed line.
- busywait  out  1  CPU stall.
- mem_read  out  1  block read request to instruction memory.
- mem_address  out  6  block address {tag,index}.
- mem_readdata  in  128  block from memory; byte n of block = bits [8n+7:8n].
- mem_busywait  in  1  memory busy; high while a block read is in flight.

Behaviour:
- Storage: per line, a 128-bit data word, a tag and a valid bit. Only valid bits are reset; the data and tag arrays are not reset.
- Word select: offset 0 = data[31:0], 1 = [63:32], 2 = [95:64], 3 = [127:96].
- hit = valid[index] && tag[index] == address tag. Evaluated combinationally from the current address.
- instruction: combinational from data[index] and offset. Meaningful only while read=1 and busywait=0.
- FSM states: IDLE, MEM_READ, UPDATE. Reset state is IDLE.
- IDLE:
  - busywait = read && !hit, combinational.
  - On posedge with read && !hit: latch {tag,index} into a miss register, go to MEM_READ.
  - read=0: busywait=0, no state change.
- MEM_READ:
  - mem_read=1, mem_address=latched {tag,index}, busywait=1.
  - Go to UPDATE on the first posedge where mem_busywait=0. Memory raises mem_busywait in the same delta as mem_read, so the first cycle never exits falsely.
- UPDATE:
  - mem_read=0, busywait=1.
  - At posedge: data[idx]=mem_readdata, tag[idx]=latched tag, valid[idx]=1. Go to IDLE.
- Miss latency = cycles memory holds mem_busywait + 2. The request then completes as a hit in IDLE (busywait drops combinationally).
- Reset values:
  - busywait=0, mem_read=0, mem_address=0, state IDLE, all valid=0.
  - instruction is undefined until the first fill.
- Boundary conditions:
  - Address changes during a miss: the fill uses the latched tag/index. The new address is evaluated on return to IDLE.
  - read drops mid-miss: the fill still completes (the memory transaction cannot be aborted). Return to IDLE; busywait=0 once read=0.
  - Conflict (same index, different tag): the line is overwritten. No write-back; the cache is read-only.
  - Reset mid-miss: immediately IDLE, mem_read=0, valid cleared. A fill in flight is discarded and later mem_readdata is ignored.
  - Hit and the posedge of the last fill cycle: no overlap, because UPDATE always precedes IDLE.

Optional Feature:
- Macro ICACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0], reset to 0.
  - miss_count increments on each IDLE→MEM_READ transition.
  - hit_count increments on each posedge in IDLE with read && hit.
  - Both saturate at 16'hFFFF.
- Not defined: ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Cold miss: after reset, read=1, address=0 → busywait=1, mem_read=1, mem_address=0. After mem_busywait falls: UPDATE, then busywait=0, instruction=32'h0001000F.
- Same-block hit: address=4 after the cold-miss fill → busywait stays 0, instruction=32'h0002000C, mem_read stays 0. Address=12 → 32'h03010103.
- Second line: address=64 (index 4) → miss with mem_address=6'd4, then instruction=32'h0F060022. Address=0 still hits.
- Conflict eviction: address=128 (tag 1, index 0) misses with mem_address=6'd8. Address=0 then misses again and refills, mem_address=0.
- Async reset mid-MEM_READ: reset pulses between clock edges → mem_read and busywait fall without a clock edge. Address=0 then misses again.
- Stats (ICACHE_STATS_EN): fetch sequence 0,4,8,64,0 → miss_count=2, hit_count=3.
